// File: rtl/counter_param_async_reset.sv
// Parametrised up/down counter with wrap or saturate boundary mode,
// synchronous clear/load, terminal-count pulse and sticky overflow.
module counter_param_async_reset #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] result,
  output logic             tc,
  output logic             overflow,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] result_nx;
  logic             tc_nx;
  logic             overflow_nx;
  logic [WIDTH-1:0] load_clamped;

  assign at_max = (result == MAX_VALUE);
  assign at_min = (result == '0);

  assign load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

  always_comb begin
    result_nx   = result;
    tc_nx       = 1'b0;
    overflow_nx = overflow;
    if (clear) begin
      result_nx   = '0;
      overflow_nx = 1'b0;
    end else if (load) begin
      result_nx = load_clamped;
    end else if (enable) begin
      if (up) begin
        if (at_max) begin
          result_nx   = SATURATE ? MAX_VALUE : '0;
          tc_nx       = 1'b1;
          overflow_nx = 1'b1;
        end else begin
          result_nx = result + 1'b1;
        end
      end else begin
        if (at_min) begin
          result_nx   = SATURATE ? '0 : MAX_VALUE;
          tc_nx       = 1'b1;
          overflow_nx = 1'b1;
        end else begin
          result_nx = result - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      result   <= result_nx;
      tc       <= tc_nx;
      overflow <= overflow_nx;
    end
  end

endmodule

// File: tb/tb_counter_param_async_reset.sv
// Directed bench for counter_param_async_reset across four
// parameterisations sharing one set of control inputs.
module tb_counter_param_async_reset;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up;
  logic       clear;
  logic       load;
  logic [7:0] load_value;

  logic [7:0] res [4];
  logic [3:0] tcs;
  logic [3:0] ovs;
  logic [3:0] mxs;
  logic [3:0] mns;

  int n_chk;
  int n_fail;
  int exp_r;
  int exp_tc;
  int exp_ov;

  counter_param_async_reset #(.WIDTH(8)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value),
    .result(res[0]), .tc(tcs[0]), .overflow(ovs[0]),
    .at_max(mxs[0]), .at_min(mns[0])
  );

  counter_param_async_reset #(
    .WIDTH(8), .MAX_VALUE(8'd9), .SATURATE(1'b0)
  ) u1 (
    .clk(clk), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value),
    .result(res[1]), .tc(tcs[1]), .overflow(ovs[1]),
    .at_max(mxs[1]), .at_min(mns[1])
  );

  counter_param_async_reset #(
    .WIDTH(8), .MAX_VALUE(8'd9), .SATURATE(1'b1)
  ) u2 (
    .clk(clk), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value),
    .result(res[2]), .tc(tcs[2]), .overflow(ovs[2]),
    .at_max(mxs[2]), .at_min(mns[2])
  );

  counter_param_async_reset #(
    .WIDTH(8), .MAX_VALUE(8'd100), .SATURATE(1'b0)
  ) u3 (
    .clk(clk), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value),
    .result(res[3]), .tc(tcs[3]), .overflow(ovs[3]),
    .at_max(mxs[3]), .at_min(mns[3])
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    enable = 1'b0;
    up = 1'b1;
    clear = 1'b0;
    load = 1'b0;
    load_value = 8'd0;

    @(negedge clk);
    chk("rst_result", int'(res[0]), 0);
    chk("rst_tc", int'(tcs[0]), 0);
    chk("rst_ovf", int'(ovs[0]), 0);
    chk("rst_at_min", int'(mns[0]), 1);
    chk("rst_at_max", int'(mxs[0]), 0);
    repeat (4) @(negedge clk);

    // wrap up-count over the full 8-bit range
    reset = 1'b0;
    enable = 1'b1;
    up = 1'b1;
    exp_r = 0;
    exp_ov = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_tc = (exp_r == 255);
      if (exp_tc != 0) exp_ov = 1;
      exp_r = (exp_r == 255) ? 0 : exp_r + 1;
      chk("up_result", int'(res[0]), exp_r);
      chk("up_tc", int'(tcs[0]), exp_tc);
      chk("up_ovf", int'(ovs[0]), exp_ov);
    end

    // run on to 42, then pulse reset between edges
    while (exp_r != 42) begin
      step();
      exp_r = (exp_r == 255) ? 0 : exp_r + 1;
    end
    chk("pre_rst_result", int'(res[0]), 42);
    chk("pre_rst_ovf", int'(ovs[0]), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_result", int'(res[0]), 0);
    chk("async_rst_ovf", int'(ovs[0]), 0);
    chk("async_rst_at_min", int'(mns[0]), 1);
    #6;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("restart_result", int'(res[0]), i);
    end

    // MAX_VALUE=9 wrap down-count
    pulse_reset();
    up = 1'b0;
    exp_r = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_tc = (exp_r == 0);
      exp_r = (exp_r == 0) ? 9 : exp_r - 1;
      chk("dn_result", int'(res[1]), exp_r);
      chk("dn_tc", int'(tcs[1]), exp_tc);
      chk("dn_at_min", int'(mns[1]), int'(exp_r == 0));
    end

    // MAX_VALUE=9 saturate up then down
    pulse_reset();
    up = 1'b1;
    exp_r = 0;
    exp_ov = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      exp_tc = (exp_r == 9);
      if (exp_tc != 0) exp_ov = 1;
      else exp_r = exp_r + 1;
      chk("sat_up_result", int'(res[2]), exp_r);
      chk("sat_up_tc", int'(tcs[2]), exp_tc);
      chk("sat_up_ovf", int'(ovs[2]), exp_ov);
    end
    up = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step();
      exp_tc = (exp_r == 0);
      if (exp_tc == 0) exp_r = exp_r - 1;
      chk("sat_dn_result", int'(res[2]), exp_r);
      chk("sat_dn_tc", int'(tcs[2]), exp_tc);
    end

    // MAX_VALUE=100 load clamp and clear priority
    pulse_reset();
    enable = 1'b0;
    load = 1'b1;
    load_value = 8'd200;
    step();
    chk("load_clamp", int'(res[3]), 100);
    chk("load_at_max", int'(mxs[3]), 1);
    chk("load_tc", int'(tcs[3]), 0);
    load = 1'b0;
    enable = 1'b1;
    up = 1'b1;
    step();
    chk("wrap100_result", int'(res[3]), 0);
    chk("wrap100_tc", int'(tcs[3]), 1);
    chk("wrap100_ovf", int'(ovs[3]), 1);
    load = 1'b1;
    load_value = 8'd55;
    step();
    chk("load_in_range", int'(res[3]), 55);
    chk("load_keeps_ovf", int'(ovs[3]), 1);
    clear = 1'b1;
    step();
    chk("clear_result", int'(res[3]), 0);
    chk("clear_ovf", int'(ovs[3]), 0);
    chk("clear_tc", int'(tcs[3]), 0);
    clear = 1'b0;
    load = 1'b0;

    // enable toggling on the default counter
    pulse_reset();
    chk("tog_start", int'(res[0]), 0);
    exp_r = 0;
    for (int i = 0; i < 5; i++) begin
      enable = ((i % 2) == 0);
      step();
      if (enable) exp_r++;
      chk("tog_result", int'(res[0]), exp_r);
      chk("tog_tc", int'(tcs[0]), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
